// File: rtl/axi_mem_rsp_gen.sv
// Read-response generator for axi_to_mem: pairs queued {id, last} entries with buffered
// memory read data and drives the AXI R channel, handing credits back to the request side.
module axi_mem_rsp_gen #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned RSP_DEPTH  = 4,
  parameter int unsigned CNT_WIDTH  = $clog2(RSP_DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [ID_WIDTH-1:0]   fifo_id_i,
  input  logic                  fifo_last_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_pop_o,
  input  logic                  mem_req_issued_i,
  output logic                  credit_avail_o,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_err_i,
  output logic                  r_valid_o,
  input  logic                  r_ready_i,
  output logic [ID_WIDTH-1:0]   r_id_o,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic [1:0]            r_resp_o,
  output logic                  r_last_o,
  output logic [CNT_WIDTH-1:0]  usage_o,
  output logic                  err_o
);

  localparam int unsigned PtrWidth = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] data_q [RSP_DEPTH];
  logic                  rerr_q [RSP_DEPTH];

  logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] usage_q, usage_d, credit_q, credit_d;
  logic                 err_q, err_d;

  logic handshake, full, push_ok;

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(RSP_DEPTH - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  assign full      = (usage_q == CNT_WIDTH'(RSP_DEPTH));
  assign r_valid_o = (usage_q != '0) & ~fifo_empty_i;
  assign handshake = r_valid_o & r_ready_i;
  // A push into a full buffer is still safe when the head leaves in the same cycle.
  assign push_ok   = mem_rvalid_i & (~full | handshake);

  always_comb begin
    credit_d = credit_q;
    usage_d  = usage_q;
    err_d    = err_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    unique case ({mem_req_issued_i, handshake})
      2'b10: begin
        if (credit_q == '0) err_d = 1'b1;
        else                credit_d = credit_q - CNT_WIDTH'(1);
      end
      2'b01:   credit_d = credit_q + CNT_WIDTH'(1);
      default: credit_d = credit_q;
    endcase

    unique case ({push_ok, handshake})
      2'b10:   usage_d = usage_q + CNT_WIDTH'(1);
      2'b01:   usage_d = usage_q - CNT_WIDTH'(1);
      default: usage_d = usage_q;
    endcase

    if (mem_rvalid_i && !push_ok) err_d = 1'b1;
    if (push_ok)   wr_ptr_d = ptr_inc(wr_ptr_q);
    if (handshake) rd_ptr_d = ptr_inc(rd_ptr_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credit_q <= CNT_WIDTH'(RSP_DEPTH);
      usage_q  <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      credit_q <= credit_d;
      usage_q  <= usage_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is qualified by the pointers, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      data_q[wr_ptr_q] <= mem_rdata_i;
      rerr_q[wr_ptr_q] <= mem_err_i;
    end
  end

  assign fifo_pop_o     = handshake;
  assign credit_avail_o = (credit_q != '0);
  assign r_id_o         = fifo_id_i;
  assign r_last_o       = fifo_last_i;
  assign r_data_o       = data_q[rd_ptr_q];
  assign r_resp_o       = rerr_q[rd_ptr_q] ? 2'b10 : 2'b00;
  assign usage_o        = usage_q;
  assign err_o          = err_q;

endmodule

// File: tb/tb_axi_mem_rsp_gen.sv
// Directed bench for axi_mem_rsp_gen: inputs change on the falling edge, outputs are
// sampled 1 time unit later, well away from the rising edge.
module tb_axi_mem_rsp_gen;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [IW-1:0] fifo_id;
  logic          fifo_last, fifo_empty, fifo_pop;
  logic          issued, credit_avail;
  logic          rvalid, rerr;
  logic [DW-1:0] rdata;
  logic          r_valid, r_ready, r_last;
  logic [IW-1:0] r_id;
  logic [DW-1:0] r_data;
  logic [1:0]    r_resp;
  logic [CW-1:0] usage;
  logic          err;

  int n_cmp = 0;
  int n_mis = 0;

  axi_mem_rsp_gen #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .RSP_DEPTH(4), .CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .fifo_id_i(fifo_id), .fifo_last_i(fifo_last), .fifo_empty_i(fifo_empty),
    .fifo_pop_o(fifo_pop),
    .mem_req_issued_i(issued), .credit_avail_o(credit_avail),
    .mem_rvalid_i(rvalid), .mem_rdata_i(rdata), .mem_err_i(rerr),
    .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id), .r_data_o(r_data),
    .r_resp_o(r_resp), .r_last_o(r_last), .usage_o(usage), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle();
    issued = 0; rvalid = 0; rerr = 0; rdata = '0; r_ready = 0;
  endtask

  task automatic test_reset();
    #1;
    if (r_valid !== 1'b0) begin $display("FAIL reset_rvalid got %b want 0", r_valid); n_mis++; end
    n_cmp++;
    if (fifo_pop !== 1'b0) begin $display("FAIL reset_pop got %b want 0", fifo_pop); n_mis++; end
    n_cmp++;
    if (credit_avail !== 1'b1) begin $display("FAIL reset_credit got %b want 1", credit_avail); n_mis++; end
    n_cmp++;
    if (usage !== 3'd0) begin $display("FAIL reset_usage got %0d want 0", usage); n_mis++; end
    n_cmp++;
    if (err !== 1'b0) begin $display("FAIL reset_err got %b want 0", err); n_mis++; end
    n_cmp++;
  endtask

  task automatic test_single();
    issued = 1; tick();
    issued = 0; rvalid = 1; rdata = 32'hDEADBEEF;
    fifo_empty = 0; fifo_id = 4'd3; fifo_last = 1; #1;
    if (r_valid !== 1'b0) begin $display("FAIL single_no_fallthrough got %b want 0", r_valid); n_mis++; end
    n_cmp++;
    tick();
    rvalid = 0; r_ready = 1; #1;
    if ({r_valid, r_id, r_data, r_resp, r_last, fifo_pop} !== {1'b1, 4'd3, 32'hDEADBEEF, 2'b00, 1'b1, 1'b1}) begin
      $display("FAIL single_beat got v=%b id=%0d d=%h resp=%b last=%b pop=%b want 1 3 deadbeef 00 1 1",
               r_valid, r_id, r_data, r_resp, r_last, fifo_pop);
      n_mis++;
    end
    n_cmp++;
    tick();
    r_ready = 0; fifo_empty = 1; #1;
    if (usage !== 3'd0) begin $display("FAIL single_drain usage got %0d want 0", usage); n_mis++; end
    n_cmp++;
  endtask

  task automatic test_backpressure();
    for (int i = 0; i < 4; i++) begin
      issued = 1; #1;
      if (credit_avail !== 1'b1) begin $display("FAIL bp_credit_before_%0d got %b want 1", i, credit_avail); n_mis++; end
      n_cmp++;
      tick();
    end
    issued = 0; #1;
    if (credit_avail !== 1'b0) begin $display("FAIL bp_credit_exhausted got %b want 0", credit_avail); n_mis++; end
    n_cmp++;
    fifo_empty = 0; fifo_id = 4'd1; fifo_last = 0;
    for (int i = 0; i < 4; i++) begin
      rvalid = 1; rdata = 32'h100 + i; tick();
    end
    rvalid = 0; #1;
    if ({usage, r_valid, r_data} !== {3'd4, 1'b1, 32'h100}) begin
      $display("FAIL bp_full got usage=%0d v=%b d=%h want 4 1 100", usage, r_valid, r_data); n_mis++;
    end
    n_cmp++;
    tick(); #1;
    if ({r_valid, r_data, fifo_pop} !== {1'b1, 32'h100, 1'b0}) begin
      $display("FAIL bp_stable got v=%b d=%h pop=%b want 1 100 0", r_valid, r_data, fifo_pop); n_mis++;
    end
    n_cmp++;
    for (int i = 0; i < 4; i++) begin
      fifo_id = 4'(i + 1); fifo_last = (i == 3); r_ready = 1; #1;
      if ({r_valid, fifo_pop, r_id, r_last, r_data} !== {1'b1, 1'b1, 4'(i + 1), (i == 3), 32'h100 + i}) begin
        $display("FAIL bp_beat_%0d got v=%b pop=%b id=%0d last=%b d=%h want 1 1 %0d %b %h",
                 i, r_valid, fifo_pop, r_id, r_last, r_data, i + 1, (i == 3), 32'h100 + i);
        n_mis++;
      end
      n_cmp++;
      tick();
    end
    r_ready = 0; fifo_empty = 1; #1;
    if ({usage, credit_avail} !== {3'd0, 1'b1}) begin
      $display("FAIL bp_after got usage=%0d credit=%b want 0 1", usage, credit_avail); n_mis++;
    end
    n_cmp++;
  endtask

  task automatic test_error_resp();
    for (int i = 0; i < 3; i++) begin issued = 1; tick(); end
    issued = 0;
    for (int i = 0; i < 3; i++) begin
      rvalid = 1; rdata = 32'h200 + i; rerr = (i == 1); tick();
    end
    idle(); fifo_empty = 0; fifo_last = 0; r_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      if ({r_resp, r_data} !== {((i == 1) ? 2'b10 : 2'b00), 32'h200 + i}) begin
        $display("FAIL err_beat_%0d got resp=%b d=%h want %b %h",
                 i, r_resp, r_data, ((i == 1) ? 2'b10 : 2'b00), 32'h200 + i);
        n_mis++;
      end
      n_cmp++;
      tick();
    end
    idle(); fifo_empty = 1;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin issued = 1; tick(); end
    issued = 0;
    for (int i = 0; i < 2; i++) begin rvalid = 1; rdata = 32'h300 + i; tick(); end
    rvalid = 0; #1;
    if (usage !== 3'd2) begin $display("FAIL b2b_pre usage got %0d want 2", usage); n_mis++; end
    n_cmp++;
    fifo_empty = 0; r_ready = 1; rvalid = 1; rdata = 32'h302; issued = 1; #1;
    if ({fifo_pop, r_data} !== {1'b1, 32'h300}) begin
      $display("FAIL b2b_pop got pop=%b d=%h want 1 300", fifo_pop, r_data); n_mis++;
    end
    n_cmp++;
    tick();
    idle(); fifo_empty = 1; #1;
    if ({usage, credit_avail} !== {3'd2, 1'b1}) begin
      $display("FAIL b2b_same_cycle got usage=%0d credit=%b want 2 1", usage, credit_avail); n_mis++;
    end
    n_cmp++;
    issued = 1; tick();
    issued = 0; #1;
    if ({credit_avail, err} !== {1'b0, 1'b0}) begin
      $display("FAIL b2b_credit_held got credit=%b err=%b want 0 0", credit_avail, err); n_mis++;
    end
    n_cmp++;
    for (int i = 3; i < 5; i++) begin rvalid = 1; rdata = 32'h300 + i; tick(); end
    rvalid = 0; fifo_empty = 0; r_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (r_data !== 32'h301 + i) begin
        $display("FAIL wrap_beat_%0d got d=%h want %h", i, r_data, 32'h301 + i); n_mis++;
      end
      n_cmp++;
      tick();
    end
    idle(); fifo_empty = 1; #1;
    if ({usage, credit_avail} !== {3'd0, 1'b1}) begin
      $display("FAIL wrap_after got usage=%0d credit=%b want 0 1", usage, credit_avail); n_mis++;
    end
    n_cmp++;
  endtask

  task automatic test_fifo_empty();
    issued = 1; tick();
    issued = 0; rvalid = 1; rdata = 32'h400; tick();
    rvalid = 0; r_ready = 1; fifo_empty = 1; #1;
    if ({r_valid, fifo_pop, usage} !== {1'b0, 1'b0, 3'd1}) begin
      $display("FAIL empty_hold got v=%b pop=%b usage=%0d want 0 0 1", r_valid, fifo_pop, usage); n_mis++;
    end
    n_cmp++;
    tick();
    fifo_empty = 0; #1;
    if ({r_valid, fifo_pop, r_data} !== {1'b1, 1'b1, 32'h400}) begin
      $display("FAIL empty_release got v=%b pop=%b d=%h want 1 1 400", r_valid, fifo_pop, r_data); n_mis++;
    end
    n_cmp++;
    tick();
    idle(); fifo_empty = 1; #1;
    if (usage !== 3'd0) begin $display("FAIL empty_after usage got %0d want 0", usage); n_mis++; end
    n_cmp++;
  endtask

  task automatic test_protocol_err();
    for (int i = 0; i < 4; i++) begin issued = 1; tick(); end
    issued = 0; #1;
    if (err !== 1'b0) begin $display("FAIL perr_before got %b want 0", err); n_mis++; end
    n_cmp++;
    issued = 1; tick();
    issued = 0; #1;
    if (err !== 1'b1) begin $display("FAIL perr_credit got %b want 1", err); n_mis++; end
    n_cmp++;
    tick(); tick(); #1;
    if ({err, credit_avail} !== {1'b1, 1'b0}) begin
      $display("FAIL perr_sticky got err=%b credit=%b want 1 0", err, credit_avail); n_mis++;
    end
    n_cmp++;
    for (int i = 0; i < 2; i++) begin rvalid = 1; rdata = 32'h500 + i; tick(); end
    rvalid = 0; fifo_empty = 0; #1;
    if (r_valid !== 1'b1) begin $display("FAIL perr_midburst got %b want 1", r_valid); n_mis++; end
    n_cmp++;
    rst_n = 0; #1;
    if ({usage, r_valid, credit_avail, err} !== {3'd0, 1'b0, 1'b1, 1'b0}) begin
      $display("FAIL midreset got usage=%0d v=%b credit=%b err=%b want 0 0 1 0",
               usage, r_valid, credit_avail, err);
      n_mis++;
    end
    n_cmp++;
    tick(); rst_n = 1; fifo_empty = 1; tick();
    for (int i = 0; i < 5; i++) begin rvalid = 1; rdata = 32'h600 + i; tick(); end
    rvalid = 0; #1;
    if ({usage, err} !== {3'd4, 1'b1}) begin
      $display("FAIL overflow got usage=%0d err=%b want 4 1", usage, err); n_mis++;
    end
    n_cmp++;
    rst_n = 0; tick(); rst_n = 1; tick();
  endtask

  initial begin
    rst_n = 0; idle(); fifo_empty = 1; fifo_id = '0; fifo_last = 0;
    tick();
    test_reset();
    rst_n = 1; tick();
    test_single();
    test_backpressure();
    test_error_resp();
    test_back_to_back();
    test_fifo_empty();
    test_protocol_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
